axis_gate_sequencer: RTL

Trigger-driven controller that opens an AXI4-Stream pass-through gate for a programmed number of beats after a programmed delay. It sits between an ADC/DAC sample stream and downstream DMA/packetizer logic. It sequences acquisition windows: arm, wait for trigger, delay, pass N beats, report done. The datapath is combinational pass-through; all gating comes from registered state.

---
 rtl/axis_gate_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axis_gate_sequencer.sv
// Trigger-driven AXI4-Stream gate: arm, wait for trigger edge, delay, pass N beats, report done.
// Define AXIS_GATE_DROP_EN to accept (discard) upstream samples while the gate is closed.
module axis_gate_sequencer #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_delay,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        cfg_rearm,
    input  logic                        arm,
    input  logic                        trigger,
    input  logic                        abort,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic [2:0]                  sts_state,
    output logic [CNTR_WIDTH-1:0]       sts_beats,
    output logic                        done
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StDelay = 3'd2,
        StPass  = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [CNTR_WIDTH-1:0] CntZero = '0;
    localparam logic [CNTR_WIDTH-1:0] CntOne  = CntZero + 1'b1;

    state_e                  state_q, state_d;
    logic                    trigger_q;
    logic [CNTR_WIDTH-1:0]   delay_q, delay_d;
    logic [CNTR_WIDTH-1:0]   length_q, length_d;
    logic                    rearm_q, rearm_d;
    logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]   beats_q, beats_d;

    logic                    trig_edge;
    logic                    gate_open;
    logic                    beat;
    logic                    last_beat;
    logic                    arm_accept;
    logic                    closed_ready;
    logic [CNTR_WIDTH-1:0]   beats_inc;

    assign trig_edge  = trigger & ~trigger_q;
    assign gate_open  = (state_q == StPass);
    assign beat       = gate_open & s_axis_tvalid & m_axis_tready;
    assign beats_inc  = beats_q + CntOne;
    // length 0 means unlimited, so it never completes
    assign last_beat  = beat && (length_q != CntZero) && (beats_inc == length_q);
    assign arm_accept = (state_q == StIdle) && arm && !abort;

`ifdef AXIS_GATE_DROP_EN
    assign closed_ready = aresetn;
`else
    assign closed_ready = 1'b0;
`endif

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (trig_edge) state_d = (delay_q != CntZero) ? StDelay : StPass;
            end
            StDelay: begin
                if (cnt_q <= CntOne) state_d = StPass;
            end
            StPass: begin
                if (last_beat) state_d = StDone;
            end
            StDone: begin
                state_d = rearm_q ? StArmed : StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Output logic: gate follows the registered state only
    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = closed_ready;
        if (gate_open) begin
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
        end
        done      = (state_q == StDone);
        sts_state = state_q;
        sts_beats = beats_q;
    end

    assign m_axis_tdata = s_axis_tdata;

    // Latched configuration, delay counter and beat counter
    always_comb begin
        delay_d  = delay_q;
        length_d = length_q;
        rearm_d  = rearm_q;
        cnt_d    = cnt_q;
        beats_d  = beats_q;

        if (arm_accept) begin
            delay_d  = cfg_delay;
            length_d = cfg_length;
            rearm_d  = cfg_rearm;
            beats_d  = CntZero;
        end

        if (state_q == StArmed && trig_edge) begin
            cnt_d = delay_q;
        end else if (state_q == StDelay) begin
            cnt_d = cnt_q - CntOne;
        end

        // A handshake in the abort cycle still counts
        if (beat) beats_d = beats_inc;

        if (state_q == StDone && rearm_q && !abort) beats_d = CntZero;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            trigger_q <= 1'b0;
            delay_q   <= CntZero;
            length_q  <= CntZero;
            rearm_q   <= 1'b0;
            cnt_q     <= CntZero;
            beats_q   <= CntZero;
        end else begin
            trigger_q <= trigger;
            delay_q   <= delay_d;
            length_q  <= length_d;
            rearm_q   <= rearm_d;
            cnt_q     <= cnt_d;
            beats_q   <= beats_d;
        end
    end

endmodule
